mc_control: RTL

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_pkg.sv | 33 +++
 rtl/mc_decode.sv | 78 +++++++
 rtl/mc_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mc_control_pkg.sv
// rtl/mc_control_pkg.sv - state encodings and RV32 opcode/funct constants for mc_control
package mc_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;

    localparam logic [6:0] F7_SUB     = 7'b0100000;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational instruction classifier for the mc_control FSM
module mc_decode
    import mc_control_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_lw,
    output logic        is_sw,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_sub,
    output logic        reg_write,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       writes_rd;
    logic       unused_bits;

    assign opcode      = ir[6:0];
    assign rd          = ir[11:7];
    assign funct3      = ir[14:12];
    assign funct7      = ir[31:25];
    assign unused_bits = ^ir[24:15];

    always_comb begin
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_sub    = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b1;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM: begin
                writes_rd = 1'b1;
                illegal   = 1'b0;
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                illegal   = 1'b0;
                is_sub    = (funct7 == F7_SUB) && (funct3 == F3_ADD_SUB);
            end
            OPC_JAL, OPC_JALR: begin
                is_jump   = 1'b1;
                writes_rd = 1'b1;
                illegal   = 1'b0;
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE ||
                    funct3 == F3_BLT || funct3 == F3_BGE) begin
                    is_branch = 1'b1;
                    illegal   = 1'b0;
                end
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD) begin
                    is_lw     = 1'b1;
                    writes_rd = 1'b1;
                    illegal   = 1'b0;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_WORD) begin
                    is_sw   = 1'b1;
                    illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // x0 is hardwired, so a write to it is simply dropped
    assign reg_write = writes_rd && (rd != 5'd0);

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle fetch/decode/exec/mem/wb control FSM with trap handling
module mc_control
    import mc_control_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [31:0]      instr_i,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             br_taken,
    input  logic             trap_clr,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             wr_en,
    output logic             lw_en,
    output logic             sw_en,
    output logic             sub_en,
    output logic             offset_en,
    output logic             mux_sel,
    output logic [2:0]       state_o,
    output logic             illegal,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instret
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        ir_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               ctl_valid;
    logic               offset_q;
    logic               illegal_q;
    logic               timeout_q;
    logic [CNT_W-1:0]   instret_q;
    logic               retire;
    logic               wait_expired;
    logic               fetch_entry;
    logic               mem_entry;
    logic               trap_entry;

    logic dec_lw, dec_sw, dec_branch, dec_jump, dec_sub, dec_reg_write, dec_illegal;

    mc_decode u_decode (
        .ir        (ir_q),
        .is_lw     (dec_lw),
        .is_sw     (dec_sw),
        .is_branch (dec_branch),
        .is_jump   (dec_jump),
        .is_sub    (dec_sub),
        .reg_write (dec_reg_write),
        .illegal   (dec_illegal)
    );

    always_comb begin
        state_nxt    = state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        wr_en        = 1'b0;
        retire       = 1'b0;
        wait_expired = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (wait_cnt == WAIT_MAX) begin
                    wait_expired = 1'b1;
                    state_nxt    = ST_TRAP;
                end
            end
            ST_DECODE: begin
                state_nxt = dec_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = (dec_lw || dec_sw) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_sw;
                // ack on the cycle the counter hits its limit still completes
                if (dmem_ack) begin
                    if (dec_sw) begin
                        pc_we     = 1'b1;
                        retire    = 1'b1;
                        state_nxt = run ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    wait_expired = 1'b1;
                    state_nxt    = ST_TRAP;
                end
            end
            ST_WB: begin
                pc_we     = 1'b1;
                wr_en     = dec_reg_write;
                retire    = 1'b1;
                state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                if (trap_clr) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_TRAP;
        endcase
    end

    assign fetch_entry = (state_nxt == ST_FETCH) && (state != ST_FETCH);
    assign mem_entry   = (state_nxt == ST_MEM)   && (state != ST_MEM);
    assign trap_entry  = (state_nxt == ST_TRAP)  && (state != ST_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ir_q      <= 32'd0;
            wait_cnt  <= '0;
            ctl_valid <= 1'b0;
            offset_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state <= state_nxt;
            if (ir_we) ir_q <= instr_i;

            if (fetch_entry || mem_entry) begin
                wait_cnt <= '0;
            end else if ((state == ST_FETCH && !imem_ack) || (state == ST_MEM && !dmem_ack)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            // decoded controls become visible in DECODE and drop at the next fetch
            if (fetch_entry || trap_entry) begin
                ctl_valid <= 1'b0;
                offset_q  <= 1'b0;
            end else begin
                if (ir_we) ctl_valid <= 1'b1;
                if (state == ST_EXEC) offset_q <= dec_branch ? br_taken : dec_jump;
            end

            if (state == ST_TRAP && trap_clr) begin
                illegal_q <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                if (state == ST_DECODE && dec_illegal) illegal_q <= 1'b1;
                if (wait_expired) timeout_q <= 1'b1;
            end

            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign lw_en       = ctl_valid && dec_lw;
    assign sw_en       = ctl_valid && dec_sw;
    assign sub_en      = ctl_valid && dec_sub;
    assign mux_sel     = ctl_valid && dec_jump;
    assign offset_en   = offset_q;
    assign state_o     = state;
    assign illegal     = illegal_q;
    assign timeout_err = timeout_q;
    assign instret     = instret_q;

endmodule
